// File: rtl/sprite_eval_if.sv
// sprite_eval_if: line-start request, OAM read port, view RAM write port and
// status flags of the per-scanline sprite evaluator.
// Optional feature macro: SPRITE_EVAL_DBUF_EN (double-buffered view RAM; adds
// the bank address bit to viewWrAddr and the viewRdBank output).
interface sprite_eval_if #(
  parameter int SPRITE_NUM_MAX = 8,
  parameter int OAM_NUM        = 64
);
  localparam int AW = $clog2(OAM_NUM);
  localparam int SW = $clog2(SPRITE_NUM_MAX);
  localparam int CW = SW + 1;
`ifdef SPRITE_EVAL_DBUF_EN
  localparam int WAW = SW + 1;
`else
  localparam int WAW = SW;
`endif

  // Line request
  logic           lineStart;
  logic [7:0]     gameLineY;
  // OAM read port (data returns one cycle after the strobe)
  logic [AW-1:0]  oamAddr;
  logic           oamRdEn;
  logic [31:0]    oamDataI;
  // View RAM write port
  logic           viewWrEn;
  logic [WAW-1:0] viewWrAddr;
  logic [31:0]    viewWrData;
  // Status
  logic [CW-1:0]  viewCount;
  logic           spriteOverflow;
  logic           busy;
  logic           done;
`ifdef SPRITE_EVAL_DBUF_EN
  logic           viewRdBank;

  modport master (
    input  lineStart, gameLineY, oamDataI,
    output oamAddr, oamRdEn, viewWrEn, viewWrAddr, viewWrData,
           viewCount, spriteOverflow, busy, done, viewRdBank
  );
  modport slave (
    output lineStart, gameLineY, oamDataI,
    input  oamAddr, oamRdEn, viewWrEn, viewWrAddr, viewWrData,
           viewCount, spriteOverflow, busy, done, viewRdBank
  );
`else
  modport master (
    input  lineStart, gameLineY, oamDataI,
    output oamAddr, oamRdEn, viewWrEn, viewWrAddr, viewWrData,
           viewCount, spriteOverflow, busy, done
  );
  modport slave (
    output lineStart, gameLineY, oamDataI,
    input  oamAddr, oamRdEn, viewWrEn, viewWrAddr, viewWrData,
           viewCount, spriteOverflow, busy, done
  );
`endif
endinterface

// File: rtl/sprite_eval.sv
// sprite_eval: per-scanline sprite evaluator. On an accepted lineStart it
// reads every OAM entry, copies the first SPRITE_NUM_MAX whose 8-line extent
// covers the requested line into the view RAM, pads the remaining slots with
// hidden entries (posY = 240) and flags overflow.
// Optional feature macro: SPRITE_EVAL_DBUF_EN (two view RAM banks; writes go
// to the bank not being read, viewRdBank flips the cycle after done).
module sprite_eval #(
  parameter int SPRITE_NUM_MAX = 8,
  parameter int OAM_NUM        = 64,
  parameter int TILE_H         = 8
) (
  input  logic           clk,
  input  logic           rstn,
  sprite_eval_if.master  bus
);
  localparam int AW  = $clog2(OAM_NUM);
  localparam int SW  = $clog2(SPRITE_NUM_MAX);
  localparam int CW  = SW + 1;
`ifdef SPRITE_EVAL_DBUF_EN
  localparam int WAW = SW + 1;
`else
  localparam int WAW = SW;
`endif

  localparam logic [AW-1:0] ADDR_LAST = AW'(OAM_NUM - 1);
  localparam logic [CW-1:0] NUM_MAX_C = CW'(SPRITE_NUM_MAX);
  localparam logic [7:0]    TILE_H_C  = 8'(TILE_H);
  localparam logic [31:0]   HIDDEN    = 32'h00F0_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FILL, ST_DONE} state_e;

  state_e          state_q;
  logic [7:0]      line_y_q;
  logic [AW-1:0]   addr_q;
  logic            rd_en_q;
  logic            rd_vld_q;   // oamDataI carries an entry this cycle
  logic [CW-1:0]   count_q;    // hits written so far
  logic [CW-1:0]   slot_q;     // next view slot to write
  logic            wr_en_q;
  logic [WAW-1:0]  wr_addr_q;
  logic [31:0]     wr_data_q;
  logic [CW-1:0]   view_count_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;
  logic            bank_q;

  logic [8:0]      diff;
  logic            hit;
  logic [WAW-1:0]  wr_addr_d;

  // Vertical hit test on the returning OAM entry; the 9-bit difference makes
  // sprites below the line (posY > lineY) borrow instead of wrapping.
  // NOTE: combinational blocks assign every output on every path, otherwise a
  // latch is inferred.
  always_comb begin
    diff = {1'b0, line_y_q} - {1'b0, bus.oamDataI[23:16]};
    hit  = (diff[8] == 1'b0) && (diff[7:0] < TILE_H_C);
  end

  // View RAM address for the next write: slot, plus the back bank when
  // double-buffered.
  always_comb begin
`ifdef SPRITE_EVAL_DBUF_EN
    wr_addr_d = {~bank_q, slot_q[SW-1:0]};
`else
    wr_addr_d = slot_q[SW-1:0];
`endif
  end

  // Evaluation FSM with registered outputs: IDLE -> SCAN -> FILL -> DONE.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      line_y_q     <= '0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_vld_q     <= 1'b0;
      count_q      <= '0;
      slot_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      view_count_q <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bank_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.lineStart) begin
            line_y_q <= bus.gameLineY;
            addr_q   <= '0;
            rd_en_q  <= 1'b1;
            rd_vld_q <= 1'b0;
            count_q  <= '0;
            slot_q   <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Address issue runs one cycle ahead of the returning data.
          if (rd_en_q) begin
            if (addr_q == ADDR_LAST) rd_en_q <= 1'b0;
            else                     addr_q  <= addr_q + AW'(1);
          end
          rd_vld_q <= rd_en_q;
          if (rd_vld_q && hit) begin
            if (count_q < NUM_MAX_C) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wr_addr_d;
              wr_data_q <= bus.oamDataI;
              count_q   <= count_q + CW'(1);
              slot_q    <= slot_q + CW'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end
          // Last entry is being consumed once the issue side has stopped.
          if (rd_vld_q && !rd_en_q) state_q <= ST_FILL;
        end
        ST_FILL: begin
          if (slot_q < NUM_MAX_C) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= HIDDEN;
            slot_q    <= slot_q + CW'(1);
          end else begin
            done_q       <= 1'b1;
            view_count_q <= count_q;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
`ifdef SPRITE_EVAL_DBUF_EN
          bank_q  <= ~bank_q;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.oamAddr        = addr_q;
  assign bus.oamRdEn        = rd_en_q;
  assign bus.viewWrEn       = wr_en_q;
  assign bus.viewWrAddr     = wr_addr_q;
  assign bus.viewWrData     = wr_data_q;
  assign bus.viewCount      = view_count_q;
  assign bus.spriteOverflow = ovf_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
`ifdef SPRITE_EVAL_DBUF_EN
  assign bus.viewRdBank     = bank_q;
`endif

endmodule

// File: tb/tb_sprite_eval.sv
// tb_sprite_eval: self-checking bench for sprite_eval. A behavioural model
// derives the whole per-cycle output schedule of each line from the OAM
// contents; one negedge process compares the DUT against it every cycle.
// Works with or without SPRITE_EVAL_DBUF_EN.
module tb_sprite_eval;
  localparam int N  = 8;
  localparam int ON = 64;
  localparam int TH = 8;
  localparam int W  = 127;
`ifdef SPRITE_EVAL_DBUF_EN
  localparam int DBUF = 1;
`else
  localparam int DBUF = 0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  sprite_eval_if #(.SPRITE_NUM_MAX(N), .OAM_NUM(ON)) bus();
  sprite_eval #(.SPRITE_NUM_MAX(N), .OAM_NUM(ON), .TILE_H(TH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // OAM RAM: synchronous read, data one cycle after the strobe.
  logic [31:0] oam [ON];
  always @(posedge clk) if (bus.oamRdEn) bus.oamDataI <= oam[bus.oamAddr];

  // View RAM image built from the DUT's write port.
  logic [31:0] view_mem [16];
  always @(posedge clk) if (rstn && bus.viewWrEn) view_mem[bus.viewWrAddr] <= bus.viewWrData;

  // Expected outputs per cycle relative to the lineStart cycle.
  bit          e_busy [W+1];
  bit          e_done [W+1];
  bit          e_rd   [W+1];
  bit          e_wr   [W+1];
  bit          e_ovf  [W+1];
  bit          e_bank [W+1];
  int          e_oaddr[W+1];
  int          e_waddr[W+1];
  int          e_vc   [W+1];
  logic [31:0] e_wdata[W+1];
  int prev_vc = 0, prev_ovf = 0, prev_bank = 0, wbank = 0;

  int pc = 0;
  int t0 = -100000;
  bit chk_en = 1'b0;
  int done_cnt = 0, wr_cnt = 0, done_rel = -1, run_writes = 0;
  int cmp_rel, cmp_i;

  always @(posedge clk) pc <= pc + 1;

  task automatic reset_model();
    for (int c = 0; c <= W; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_wr[c] = 0;
      e_ovf[c] = 0; e_bank[c] = 0; e_oaddr[c] = 0; e_waddr[c] = 0;
      e_vc[c] = 0; e_wdata[c] = '0;
    end
    prev_vc = 0; prev_ovf = 0; prev_bank = 0;
  endtask

  // Which sprites cover the line, and when each output event must happen.
  task automatic build_model(input logic [7:0] ly);
    int sel[$];
    int ovf_k, done_c, py, lyi, c;
    lyi = int'(ly);
    ovf_k = -1;
    for (int k = 0; k < ON; k++) begin
      py = int'(oam[k][23:16]);
      if (lyi >= py && lyi - py < TH) begin
        if (sel.size() < N) sel.push_back(k);
        else if (ovf_k < 0) ovf_k = k;
      end
    end
    wbank  = DBUF ? (prev_bank ^ 1) : 0;
    done_c = ON + 3 + (N - sel.size());
    for (int cc = 0; cc <= W; cc++) begin
      e_busy[cc]  = (cc >= 1 && cc <= done_c);
      e_done[cc]  = (cc == done_c);
      e_rd[cc]    = (cc >= 1 && cc <= ON);
      e_oaddr[cc] = cc - 1;
      e_wr[cc]    = 0;
      e_waddr[cc] = 0;
      e_wdata[cc] = '0;
      e_ovf[cc]   = (cc == 0) ? (prev_ovf != 0) : (ovf_k >= 0 && cc >= ovf_k + 3);
      e_vc[cc]    = (cc >= done_c) ? sel.size() : prev_vc;
      e_bank[cc]  = (cc > done_c) ? (wbank != 0) : (prev_bank != 0);
    end
    foreach (sel[j]) begin
      c = sel[j] + 3;
      e_wr[c] = 1; e_waddr[c] = wbank * N + j; e_wdata[c] = oam[sel[j]];
    end
    for (int j = sel.size(); j < N; j++) begin
      c = ON + 3 + (j - sel.size());
      e_wr[c] = 1; e_waddr[c] = wbank * N + j; e_wdata[c] = 32'h00F0_0000;
    end
    prev_vc  = sel.size();
    prev_ovf = (ovf_k >= 0);
    prev_bank = wbank;
  endtask

  // Single compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_rel = pc - t0;
      cmp_i   = (cmp_rel < 0 || cmp_rel > W) ? W : cmp_rel;
      check("busy",     32'(bus.busy),           32'(e_busy[cmp_i]));
      check("done",     32'(bus.done),           32'(e_done[cmp_i]));
      check("oamRdEn",  32'(bus.oamRdEn),        32'(e_rd[cmp_i]));
      check("viewWrEn", 32'(bus.viewWrEn),       32'(e_wr[cmp_i]));
      check("overflow", 32'(bus.spriteOverflow), 32'(e_ovf[cmp_i]));
      check("viewCount",32'(bus.viewCount),      32'(e_vc[cmp_i]));
      if (e_rd[cmp_i]) check("oamAddr", 32'(bus.oamAddr), 32'(e_oaddr[cmp_i]));
      if (e_wr[cmp_i]) begin
        check("viewWrAddr", 32'(bus.viewWrAddr), 32'(e_waddr[cmp_i]));
        check("viewWrData", bus.viewWrData, e_wdata[cmp_i]);
      end
`ifdef SPRITE_EVAL_DBUF_EN
      check("viewRdBank", 32'(bus.viewRdBank), 32'(e_bank[cmp_i]));
`endif
      if (bus.done) begin done_cnt++; done_rel = cmp_rel; end
      if (bus.viewWrEn) wr_cnt++;
    end
  end

  function automatic int vaddr(input int j);
    return wbank * N + j;
  endfunction

  task automatic start_line(input logic [7:0] ly);
    @(posedge clk); #1;
    build_model(ly);
    t0 = pc;
    bus.lineStart = 1'b1;
    bus.gameLineY = ly;
    @(posedge clk); #1;
    bus.lineStart = 1'b0;
    bus.gameLineY = 8'($urandom);
  endtask

  task automatic run_line(input logic [7:0] ly, input int glitch_c);
    int d0, w0, n;
    d0 = done_cnt; w0 = wr_cnt; n = 0;
    start_line(ly);
    while (done_cnt == d0 && n < 200) begin
      bus.lineStart = (pc - t0 == glitch_c);
      @(posedge clk); #1;
      n++;
    end
    bus.lineStart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    run_writes = wr_cnt - w0;
  endtask

  task automatic load_boundary();
    for (int k = 0; k < ON; k++) oam[k] = 32'h00F0_0000;
    oam[5]  = 32'h1103_2A05;   // posY 3: diff 7, hit
    oam[9]  = 32'h220A_3B09;   // posY 10: diff 0, hit
    oam[12] = 32'h3302_0000;   // posY 2: diff 8, miss
    oam[20] = 32'h440B_0000;   // posY 11: borrow, miss
  endtask

  task automatic load_overflow();
    for (int k = 0; k < ON; k++) oam[k] = 32'h00F0_0000;
    for (int k = 0; k < 10; k++) oam[k] = {8'(k), 8'd20, 8'hA0, 8'(k)};
  endtask

  initial begin
    int d, py, lyr;
    bus.lineStart = 1'b0;
    bus.gameLineY = '0;
    #3 rstn = 1'b0;
    reset_model();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // All sprites hidden: full fill, no hits.
    for (int k = 0; k < ON; k++) oam[k] = 32'h00F0_0000;
    run_line(8'd10, -1);
    check("t1_done_cycle", 32'(done_rel), 32'd75);
    check("t1_count", 32'(bus.viewCount), 32'd0);
    check("t1_overflow", 32'(bus.spriteOverflow), 32'd0);
    check("t1_writes", 32'(run_writes), 32'd8);
    for (int j = 0; j < N; j++) check("t1_slot", view_mem[vaddr(j)], 32'h00F0_0000);
`ifdef SPRITE_EVAL_DBUF_EN
    check("t1_bank", 32'(bus.viewRdBank), 32'd1);
`endif

    // Vertical boundaries.
    load_boundary();
    run_line(8'd10, -1);
    check("t2_slot0", view_mem[vaddr(0)], 32'h1103_2A05);
    check("t2_slot1", view_mem[vaddr(1)], 32'h220A_3B09);
    check("t2_slot2", view_mem[vaddr(2)], 32'h00F0_0000);
    check("t2_count", 32'(bus.viewCount), 32'd2);
    check("t2_done_cycle", 32'(done_rel), 32'd73);
`ifdef SPRITE_EVAL_DBUF_EN
    check("t2_bank", 32'(bus.viewRdBank), 32'd0);
`endif

    // Overflow: ten hits, only the first eight kept, no fill.
    load_overflow();
    run_line(8'd22, -1);
    check("t3_overflow", 32'(bus.spriteOverflow), 32'd1);
    check("t3_count", 32'(bus.viewCount), 32'd8);
    check("t3_done_cycle", 32'(done_rel), 32'd67);
    check("t3_writes", 32'(run_writes), 32'd8);
    check("t3_slot7", view_mem[vaddr(7)], 32'h0714_A007);

    // lineStart while busy is dropped.
    load_boundary();
    run_line(8'd10, 30);
    check("t4_count", 32'(bus.viewCount), 32'd2);
    check("t4_slot1", view_mem[vaddr(1)], 32'h220A_3B09);

    // Asynchronous reset in the middle of a scan, then a clean line.
    load_overflow();
    start_line(8'd22);
    while (pc - t0 < 40) begin @(posedge clk); #1; end
    rstn = 1'b0;
    reset_model();
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rden", 32'(bus.oamRdEn), 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    run_line(8'd22, -1);
    check("t5_count", 32'(bus.viewCount), 32'd8);
    check("t5_overflow", 32'(bus.spriteOverflow), 32'd1);

    // Randomized lines.
    for (int r = 0; r < 24; r++) begin
      d   = $urandom_range(1, 12);
      lyr = $urandom_range(0, 239);
      for (int k = 0; k < ON; k++) begin
        if ($urandom_range(0, d) == 0) begin
          py = lyr - $urandom_range(0, 9);
          if (py < 0) py = 250;
        end else begin
          py = $urandom_range(0, 255);
        end
        oam[k] = {8'($urandom), 8'(py), 16'($urandom)};
      end
      run_line(8'(lyr), ($urandom_range(0, 1) == 1) ? $urandom_range(2, 60) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_eval.md
# sprite_eval

Per-scanline sprite evaluator. It writes the sprite view RAM that the per-tile sprite draw units read from. On each line-start pulse it scans all OAM entries in the full sprite attribute RAM and picks those whose 8-line vertical extent covers the requested game line. It copies up to `SPRITE_NUM_MAX` of them into the view RAM, pads the remaining slots with hidden entries, and flags overflow.

## Interface
Parameters:
- `SPRITE_NUM_MAX`, 8: view RAM slots.
- `OAM_NUM`, 64: OAM entries scanned per line.
- `TILE_H`, 8: sprite height in lines.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `lineStart` in 1: one-cycle request pulse to evaluate `gameLineY`.
- `gameLineY` in 8: game-area line to evaluate (0..239). Sampled only with an accepted `lineStart`.
- `oamAddr` out $clog2(OAM_NUM): OAM read address.
- `oamRdEn` out 1: OAM read strobe.
- `oamDataI` in 32: OAM entry `{posX, posY, tileIndex, attr}`. Valid one cycle after `oamAddr`/`oamRdEn`.
- `viewWrEn` out 1: view RAM write strobe.
- `viewWrAddr` out $clog2(SPRITE_NUM_MAX) (+1 with `SPRITE_EVAL_DBUF_EN`): view RAM slot.
- `viewWrData` out 32: entry written, same format as `oamDataI`.
- `viewCount` out $clog2(SPRITE_NUM_MAX)+1: sprites selected on the last line.
- `spriteOverflow` out 1: more than `SPRITE_NUM_MAX` hits on the last line.
- `busy` out 1: evaluation in progress.
- `done` out 1: one-cycle completion pulse.
- `viewRdBank` out 1: bank the draw units read. Present only with `SPRITE_EVAL_DBUF_EN`.

## Operation
- FSM states: IDLE → SCAN → FILL → DONE → IDLE.
- **IDLE**
  - `lineStart` is accepted only in IDLE. Pulses that arrive while `busy` are dropped with no side effect.
  - On acceptance: latch `gameLineY` into `lineY`, clear the hit counter and `spriteOverflow`, then go to SCAN.
- **SCAN**
  - Issue addresses 0..`OAM_NUM`-1, one per cycle, with `oamRdEn`=1.
  - For each returned entry, hit = `diff[8]==0 && diff[7:0] < TILE_H`, where `diff = {1'b0,lineY} - {1'b0,posY}`. The subtraction is 9-bit, so there is no wrap-around.
  - On a hit with count < `SPRITE_NUM_MAX`: write the entry unmodified to slot `count`, then `count++`.
  - On a hit with count == `SPRITE_NUM_MAX`: set `spriteOverflow`; nothing is written.
  - The scan always completes all `OAM_NUM` entries. Lower OAM index has priority.
- **FILL**
  - Write the hidden entry `32'h00F0_0000` (posY = 240) to slots `count`..`SPRITE_NUM_MAX`-1, one per cycle. Because posY = 240, these entries never hit any game line.
  - FILL is skipped when count == `SPRITE_NUM_MAX`.
- **DONE**
  - `done`=1 for one cycle.
  - `viewCount` is updated to the final count and held until the next DONE.
- Reset mid-operation: every state and output returns to its reset value immediately. Partially written view RAM contents are left as they are.

## Timing
- Reset values: `oamAddr`=0, `oamRdEn`=0, `viewWrEn`=0, `viewWrAddr`=0, `viewWrData`=0, `viewCount`=0, `spriteOverflow`=0, `busy`=0, `done`=0, `viewRdBank`=0.
- All outputs are registered.
- Per-cycle schedule, with cycle 0 being the cycle in which `lineStart` is sampled:
  - Cycle k+1 (k = 0..`OAM_NUM`-1): `oamAddr`=k, `oamRdEn`=1.
  - Cycle k+2: entry k is valid on `oamDataI`.
  - Cycle k+3: write for entry k, if it hit.
  - Fill writes occupy cycles `OAM_NUM`+3 .. `OAM_NUM`+2+(`SPRITE_NUM_MAX`-count).
  - `done` is asserted in cycle `OAM_NUM`+3+(`SPRITE_NUM_MAX`-count).
- `busy` is high from cycle 1 through the `done` cycle, inclusive.
- Defaults: 67..75 cycles per line. The clock must be fast enough to complete within hblank.

## Configuration
- `SPRITE_EVAL_DBUF_EN` defined (double-buffered):
  - The view RAM has two banks, selected by the MSB of `viewWrAddr`.
  - Writes always target bank `~viewRdBank`.
  - `viewRdBank` toggles in the cycle after `done`. Evaluation may therefore overlap active display of the current line.
- `SPRITE_EVAL_DBUF_EN` undefined (single-buffered):
  - Single bank. `viewRdBank` and the bank address bit do not exist.
  - The system must issue `lineStart` so that evaluation completes within hblank.

## Test plan
- OAM all posY=0xF0, `gameLineY`=10 → 8 writes of `32'h00F0_0000` to slots 0..7, `viewCount`=0, `spriteOverflow`=0, `done` at cycle 75.
- Entry 5 posY=3 and entry 9 posY=10 (boundary checks), line 10:
  - Slot 0 = entry 5 (diff = 7, hit).
  - Slot 1 = entry 9 (diff = 0, hit).
  - An entry with posY=2 does not hit (diff = 8).
  - An entry with posY=11 does not hit (9-bit borrow).
  - `viewCount`=2.
- 10 entries at indexes 0..9 all posY=20, line 22 → slots 0..7 = entries 0..7, `spriteOverflow`=1, no fill writes, `done` at cycle 67.
- `lineStart` re-pulsed at cycle 30 of an evaluation → ignored, single `done`, results unchanged.
- `rstn` low at cycle 40 → all outputs 0 asynchronously; next `lineStart` runs a complete, correct evaluation.
- With `SPRITE_EVAL_DBUF_EN`: two consecutive lines → writes go to banks 1 then 0; `viewRdBank` is 1 after the first `done`+1 and 0 after the second.
